// File: rtl/uart_pkg.sv
// Shared UART encodings: frame length, parity selection and FSM state types.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    // len field: number of data bits minus five
    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    // parity_type field; 2'b11 is reserved and behaves as no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Number of data bits carried by a frame (5..8)
    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return 4'd5 + {2'b00, len};
    endfunction

    // Only odd and even carry a parity bit on the wire
    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: synchronizer, per-tick previous sample, falling-edge flag, bit value (UART_RX_MAJORITY_EN selects 2-of-3 vote).
// Latency: SYNC_STAGES clk from data_in to line; bit_val/fall are combinational from registered state.
// Backpressure: none; free-running, history advances only on sample_tick.
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic data_in,
    output logic bit_val,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;
    logic                   prev_q;

    // Synchronizer chain; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    assign line = sync_q[SYNC_STAGES-1];

    // Line value seen on the previous sample tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else if (sample_tick) begin
            prev_q <= line;
        end
    end

    // High-to-low between consecutive ticks; the FSM qualifies it with sample_tick
    assign fall = prev_q & ~line;

`ifdef UART_RX_MAJORITY_EN
    logic prev2_q;

    // Second history stage for the three-sample vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev2_q <= 1'b1;
        end else if (sample_tick) begin
            prev2_q <= prev_q;
        end
    end

    // Vote over the current tick and the two ticks before it
    assign bit_val = (line & prev_q) | (line & prev2_q) | (prev_q & prev2_q);
`else
    assign bit_val = line;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits LSB first, optional odd/even parity, one stop bit.
// Latency: rx_valid one clk after the tick that samples the stop-bit centre (~9.5 bit times for 8N1).
// Backpressure: none; word and flags hold until the next rx_valid, host must capture before then.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre instead of one sample.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       data_in,
    input  logic [1:0] len,
    input  logic [1:0] parity_type,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_active,
    output logic       rx_done
);

    import uart_pkg::*;

    localparam int             CW        = $clog2(OVERSAMPLE);
    // Start bit is checked half a bit after the edge; later bits one full bit apart
    localparam logic [CW-1:0]  HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(OVERSAMPLE - 1);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    len_q;
    logic [1:0]    ptype_q;
    logic [7:0]    shift_q;
    logic          par_acc;
    logic          pe_pend;
    logic          bit_val;
    logic          fall;
    logic [7:0]    word_aligned;

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .data_in     (data_in),
        .bit_val     (bit_val),
        .fall        (fall)
    );

    // Bits enter at the top of shift_q, so a short word sits high; shift it down by 8-(len+5)
    assign word_aligned = shift_q >> (2'd3 - len_q);

    // Receive FSM: every step is gated by sample_tick; rx_valid is a one-clk pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RX_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            len_q         <= LEN_8;
            ptype_q       <= PAR_NONE;
            shift_q       <= '0;
            par_acc       <= 1'b0;
            pe_pend       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            rx_active     <= 1'b0;
            rx_done       <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            if (sample_tick) begin
                case (state)
                    RX_IDLE: begin
                        // Frame format is frozen here so mid-frame changes are ignored
                        if (fall) begin
                            len_q     <= len;
                            ptype_q   <= parity_type;
                            cnt       <= '0;
                            state     <= RX_START;
                            rx_active <= 1'b1;
                            rx_done   <= 1'b0;
                        end
                    end
                    RX_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt <= '0;
                            if (bit_val) begin
                                // Line back high at mid-start: treat as a glitch
                                state     <= RX_IDLE;
                                rx_active <= 1'b0;
                                rx_done   <= 1'b1;
                            end else begin
                                state   <= RX_DATA;
                                bit_idx <= '0;
                                par_acc <= 1'b0;
                                pe_pend <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            shift_q <= {bit_val, shift_q[7:1]};
                            par_acc <= par_acc ^ bit_val;
                            bit_idx <= bit_idx + 1'b1;
                            if ({1'b0, bit_idx} == data_bits(len_q) - 4'd1) begin
                                state <= parity_enabled(ptype_q) ? RX_PARITY : RX_STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_PARITY: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            // Odd wants total XOR of 1, even wants 0
                            pe_pend <= (par_acc ^ bit_val) != (ptype_q == PAR_ODD);
                            state   <= RX_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt           <= '0;
                            rx_data       <= word_aligned;
                            parity_error  <= pe_pend;
                            framing_error <= ~bit_val;
                            rx_valid      <= 1'b1;
                            rx_active     <= 1'b0;
                            rx_done       <= 1'b1;
                            state         <= RX_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= RX_IDLE;
                        rx_active <= 1'b0;
                        rx_done   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, queue-based expected words, per-cycle output compare.
// Latency: sample_tick every 4 clk, 64 clk per bit.
// Backpressure: n/a.
module tb_uart_rx;

    localparam int CPT = 4;          // clk per sample tick
    localparam int CPB = CPT * 16;   // clk per bit

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       data_in = 1'b1;
    logic [1:0] len = 2'b11;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       rx_active;
    logic       rx_done;

    uart_rx #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .data_in       (data_in),
        .len           (len),
        .parity_type   (parity_type),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .rx_active     (rx_active),
        .rx_done       (rx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } word_t;

    word_t exp_q[$];
    word_t last;
    int    checks = 0;
    int    errors = 0;
    int    valid_cnt = 0;
    int    active_clks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // What a receiver must report for the frame on the wire
    function automatic word_t model(input logic [7:0] d, input int nbits, input logic [1:0] pt,
                                    input logic par_b, input logic stop_b);
        word_t w;
        int    ones;
        w.data = d & 8'((1 << nbits) - 1);
        ones   = $countones(w.data) + int'(par_b);
        if (pt == 2'b01)      w.pe = (ones % 2) != 1;
        else if (pt == 2'b10) w.pe = (ones % 2) != 0;
        else                  w.pe = 1'b0;
        w.fe = !stop_b;
        return w;
    endfunction

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input logic glitch);
        if (glitch) begin
            data_in = b;  clks(30);
            data_in = ~b; clks(CPT);
            data_in = b;  clks(CPB - 30 - CPT);
        end else begin
            data_in = b;
            clks(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] pt,
                              input logic par_b, input logic stop_b, input int glitch_bit);
        len         = 2'(nbits - 5);
        parity_type = pt;
        exp_q.push_back(model(d, nbits, pt, par_b, stop_b));
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], glitch_bit == i);
        if (pt == 2'b01 || pt == 2'b10) drive_bit(par_b, 1'b0);
        drive_bit(stop_b, 1'b0);
        data_in = 1'b1;
        clks(CPB);
    endtask

    // Sample tick generator
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k = (k + 1) % CPT;
            sample_tick = (k == 0);
        end
    end

    // Compare process: outputs against the expected-word queue every cycle
    initial begin
        word_t e;
        last = '{8'h00, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            check("done_is_not_active", rx_done, !rx_active);
            if (!rst_n) begin
                check("rst_rx_data", rx_data, 8'h00);
                check("rst_rx_valid", rx_valid, 1'b0);
                check("rst_parity_error", parity_error, 1'b0);
                check("rst_framing_error", framing_error, 1'b0);
                check("rst_rx_active", rx_active, 1'b0);
                last = '{8'h00, 1'b0, 1'b0};
            end else if (rx_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: rx_valid with data %0h, no word expected", rx_data);
                    last = '{rx_data, parity_error, framing_error};
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", rx_data, e.data);
                    check("word_parity_error", parity_error, e.pe);
                    check("word_framing_error", framing_error, e.fe);
                    last = e;
                end
            end else begin
                check("hold_data", rx_data, last.data);
                check("hold_parity_error", parity_error, last.pe);
                check("hold_framing_error", framing_error, last.fe);
            end
            if (rx_active) active_clks++;
        end
    end

    // Directed scenarios
    initial begin
        int v;
        clks(5);
        rst_n = 1'b1;
        clks(CPB);

        // 8N1 0xA5; rx_active spans start edge to stop centre = 9.5 bits
        active_clks = 0;
        send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b1, -1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_pe", parity_error, 1'b0);
        check("a5_fe", framing_error, 1'b0);
        check("a5_valid_count", valid_cnt, 1);
        check("a5_active_clks", active_clks, 608);

        // 7E1 0x35 with wrong parity bit, then correct one
        send_frame(8'h35, 7, 2'b10, 1'b1, 1'b1, -1);
        check("e7_bad_data", rx_data, 8'h35);
        check("e7_bad_pe", parity_error, 1'b1);
        send_frame(8'h35, 7, 2'b10, 1'b0, 1'b1, -1);
        check("e7_good_pe", parity_error, 1'b0);

        // 5O1 0x1F with stop bit low
        send_frame(8'h1F, 5, 2'b01, 1'b0, 1'b0, -1);
        check("o5_data", rx_data, 8'h1F);
        check("o5_pe", parity_error, 1'b0);
        check("o5_fe", framing_error, 1'b1);

        // 6N1: upper bits must be zero; reserved parity code sends no parity bit
        send_frame(8'hEA, 6, 2'b00, 1'b0, 1'b1, -1);
        check("n6_data", rx_data, 8'h2A);
        send_frame(8'h81, 8, 2'b11, 1'b0, 1'b1, -1);
        check("rsvd_data", rx_data, 8'h81);
        check("rsvd_pe", parity_error, 1'b0);

        // 4-tick low glitch on idle line is rejected
        v = valid_cnt;
        len = 2'b11;
        parity_type = 2'b00;
        data_in = 1'b0;
        clks(4 * CPT);
        data_in = 1'b1;
        clks(2 * CPB);
        check("glitch_no_valid", valid_cnt, v);
        check("glitch_rx_done", rx_done, 1'b1);
        check("glitch_rx_active", rx_active, 1'b0);

`ifdef UART_RX_MAJORITY_EN
        // One-tick spike at data bit 3 centre is outvoted
        send_frame(8'h00, 8, 2'b00, 1'b0, 1'b1, 3);
        check("maj_data", rx_data, 8'h00);
        check("maj_fe", framing_error, 1'b0);
`endif

        // Break: line low for 20 bits, then 0x5A
        v = valid_cnt;
        len = 2'b11;
        parity_type = 2'b00;
        exp_q.push_back(model(8'h00, 8, 2'b00, 1'b0, 1'b0));
        data_in = 1'b0;
        clks(20 * CPB);
        check("break_valid_count", valid_cnt, v + 1);
        check("break_data", rx_data, 8'h00);
        check("break_fe", framing_error, 1'b1);
        data_in = 1'b1;
        clks(2 * CPB);
        send_frame(8'h5A, 8, 2'b00, 1'b0, 1'b1, -1);
        check("after_break_valid_count", valid_cnt, v + 2);
        check("after_break_data", rx_data, 8'h5A);
        check("after_break_fe", framing_error, 1'b0);

        // Reset pulse during data bit 4 of 0x3C
        v = valid_cnt;
        len = 2'b11;
        parity_type = 2'b00;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[0] ^ v[0] ^ (8'h3C >> i) & 1'b1, 1'b0);
        data_in = 1'b1;
        clks(CPB / 2);
        rst_n = 1'b0;
        clks(1);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_done", rx_done, 1'b1);
        clks(3);
        rst_n = 1'b1;
        clks(2 * CPB);
        check("midrst_no_valid", valid_cnt, v);
        check("midrst_rx_active", rx_active, 1'b0);
        send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b1, -1);
        check("post_rst_data", rx_data, 8'h3C);
        check("post_rst_valid_count", valid_cnt, v + 1);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver matching the team's UART transmitter frame format. It oversamples the incoming line at 16x the baud rate, detects and qualifies the start bit, and shifts in 5 to 8 data bits LSB first. It then checks an optional parity bit and the stop bit, and presents the assembled byte with a one-cycle valid strobe and error flags. It sits between the pad-side serial input and the host-side register/FIFO logic.

## Interface
Parameters:
- OVERSAMPLE, 16: sample ticks per bit; must be even and ≥ 8.
- SYNC_STAGES, 2: flops in the input synchronizer; must be ≥ 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate
- data_in  input  1  asynchronous serial line; idles high
- len  input  2  data bits: 00 = 5, 01 = 6, 10 = 7, 11 = 8
- parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none (reserved)
- rx_data  output  8  received word, right-aligned, upper unused bits 0
- rx_valid  output  1  one-clk pulse: word and flags are updated
- parity_error  output  1  parity mismatch on the last word
- framing_error  output  1  stop bit sampled low on the last word
- rx_active  output  1  high from start detect until the stop sample completes
- rx_done  output  1  high whenever the receiver is idle; the complement of rx_active

## Operation
- The serial input passes through SYNC_STAGES flops before any use. All FSM and counter activity advances only on clk edges where sample_tick = 1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge (previous tick sample 1, current 0) latches len and parity_type, clears the tick counter, and enters START. Changes to len or parity_type mid-frame have no effect.
- START: at tick OVERSAMPLE/2-1 the line is resampled. If it is 1, the start is false: return to IDLE with no rx_valid. If it is 0, clear the counter and enter DATA.
- DATA: every OVERSAMPLE ticks, sample one bit into the shift register, LSB first. After len+5 bits, go to PARITY if parity_type is 01 or 10, else to STOP.
- PARITY: sample one bit.
  - Odd parity expects XOR(data, parity) = 1.
  - Even parity expects XOR(data, parity) = 0.
  - A mismatch sets the pending parity_error.
- STOP: sample one bit. A 0 sets the pending framing_error. Then:
  - Load rx_data, right-aligned, with bits above len+5 forced to 0.
  - Load parity_error and framing_error.
  - Pulse rx_valid.
  - Return to IDLE.
- Flags and rx_data hold until the next rx_valid. A word with a framing error is still delivered.
- Break condition (line held low): the word is delivered as 0x00 with framing_error = 1. No new start is accepted until the line has been sampled high at least once, because start detection is edge-based.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_error = 0, framing_error = 0, rx_active = 0, rx_done = 1. The FSM resets to IDLE and the synchronizer flops reset to 1.
- Reset asserted mid-frame aborts the frame immediately with no rx_valid. After release, the receiver waits for a fresh falling edge.
- Input-to-detect latency is SYNC_STAGES clk cycles plus up to one tick period.
- rx_valid is registered: it asserts on the clk edge after the tick on which the stop bit is sampled, and lasts exactly one clk.
- A new start bit is detected as early as the tick after the stop sample, which tolerates about a half-bit receiver-fast baud mismatch.
- When sample_tick is held 0, all state is frozen.

## Configuration
- UART_RX_MAJORITY_EN:
  - Defined: each bit value (start check, data, parity, stop) is the 2-of-3 majority of the samples at ticks OVERSAMPLE/2-2, -1 and 0 relative to bit centre. The false-start check uses the same vote.
  - Undefined: a single sample at tick OVERSAMPLE/2-1.
- Bit-level timing is identical in both cases.

## Structure
- Shared package uart_pkg holds:
  - the len encodings and a data-bit-count function;
  - the parity_type encodings;
  - the receiver state enum.
- The transmitter's encodings move to the same package.
- One sub-module, uart_rx_sampler, contains the synchronizer, the previous-sample register (falling-edge detect) and the majority vote. It outputs a bit value and a falling-edge flag to the FSM.

## Test plan
- 8N1, line 0xA5, 16 ticks per bit → one rx_valid, rx_data = 0xA5, both error flags 0, rx_active high for 9.5 bit times.
- 7 bits, even parity, data 0x35, parity bit 1 (wrong) → rx_data = 0x35, parity_error = 1; a following correct word with parity 0 clears the flag.
- 5 bits, odd parity, data 0x1F, stop bit driven 0 → rx_data = 0x1F, framing_error = 1, parity_error = 0.
- Low glitch of 4 ticks on an idle line → no rx_valid, FSM back to IDLE, rx_done = 1. With the macro defined, a 1-tick glitch inside the data bit 3 centre window of a 0x00 word still yields 0x00.
- Line held low for 20 bit times, then released and 0x5A sent → first 0x00 with framing_error = 1; then exactly one further rx_valid with 0x5A and no errors.
- rst_n pulsed low during data bit 4 of a frame → outputs return to reset values, no rx_valid; the next full frame 0x3C is received correctly.
